// File: rtl/hw2_pkg.sv
// Shared constants and types for the hw2 multiply/accumulate datapath.
// Holds the result width, the default window, the clog2 helper and the holding-register state codes.
package hw2_pkg;

    localparam int DW          = 16;
    localparam int DEFAULT_WIN = 8;

    // Ceiling log2; clog2(1) = 0. Only ever evaluated on constants.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_t;

endpackage : hw2_pkg

// File: rtl/hw2_result_accum.sv
// Windowed sum / max / zero-count accumulator over the hw2 multiply result stream.
// Every WIN accepted samples a summary is offered on a valid/ready holding register.
module hw2_result_accum
    import hw2_pkg::*;
#(
    parameter int WIN   = DEFAULT_WIN,
    parameter int ACC_W = DW + clog2(WIN),
    parameter int ZC_W  = clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_d,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic [DW-1:0]    out_max,
    output logic [ZC_W-1:0]  out_zero_cnt,
    output logic             overrun
);

    localparam int CNT_W = clog2(WIN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

    hold_state_t      state;
    logic [ACC_W-1:0] acc;
    logic [DW-1:0]    cur_max;
    logic [ZC_W-1:0]  zc;
    logic [CNT_W-1:0] cnt;

    // Working values including the current sample; only used when in_valid is high.
    logic [ACC_W-1:0] nxt_acc;
    logic [DW-1:0]    nxt_max;
    logic [ZC_W-1:0]  nxt_zc;
    logic             complete;
    logic             hold_free;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        nxt_acc   = acc + ACC_W'(in_d);
        nxt_max   = (in_d > cur_max) ? in_d : cur_max;
        nxt_zc    = zc + ZC_W'(in_d == '0);
        complete  = in_valid && (cnt == LAST);
        hold_free = (state == ST_EMPTY) || out_ready;
    end

    // NOTE: sequential state uses non-blocking assignments; rst is synchronous and wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            acc          <= '0;
            cur_max      <= '0;
            zc           <= '0;
            cnt          <= '0;
            out_sum      <= '0;
            out_max      <= '0;
            out_zero_cnt <= '0;
            overrun      <= 1'b0;
        end else begin
            if (complete) begin
                // Window closes: working registers restart whether or not the summary is kept.
                acc     <= '0;
                cur_max <= '0;
                zc      <= '0;
                cnt     <= '0;
                if (hold_free) begin
                    state        <= ST_FULL;
                    out_sum      <= nxt_acc;
                    out_max      <= nxt_max;
                    out_zero_cnt <= nxt_zc;
                end else begin
                    overrun <= 1'b1;
                end
            end else begin
                if (in_valid) begin
                    acc     <= nxt_acc;
                    cur_max <= nxt_max;
                    zc      <= nxt_zc;
                    cnt     <= cnt + 1'b1;
                end
                if (state == ST_FULL && out_ready)
                    state <= ST_EMPTY;
            end
        end
    end

    assign out_valid = (state == ST_FULL);

endmodule : hw2_result_accum

// File: tb/tb_hw2_result_accum.sv
// Scoreboard bench for hw2_result_accum with WIN = 4: stimulus pushes expected summaries,
// a negedge monitor pops and compares on every handshake transfer.
module tb_hw2_result_accum;

    localparam int WIN   = 4;
    localparam int DW    = 16;
    localparam int ACC_W = 18;
    localparam int ZC_W  = 3;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [DW-1:0]    max;
        logic [ZC_W-1:0]  zc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [DW-1:0]    in_d;
    logic             out_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_sum;
    logic [DW-1:0]    out_max;
    logic [ZC_W-1:0]  out_zero_cnt;
    logic             overrun;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    hw2_result_accum #(.WIN(WIN), .ACC_W(ACC_W), .ZC_W(ZC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_d         (in_d),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_max      (out_max),
        .out_zero_cnt (out_zero_cnt),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [ACC_W-1:0] s, input logic [DW-1:0] m, input logic [ZC_W-1:0] z);
        exp_t e;
        e.sum = s;
        e.max = m;
        e.zc  = z;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_d     = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_rst();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: pops on transfers, and checks the held summary stays stable while stalled.
    logic             held;
    logic [ACC_W-1:0] held_sum;
    logic [DW-1:0]    held_max;
    logic [ZC_W-1:0]  held_zc;

    initial begin
        exp_t e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (held && out_valid) begin
                check("stable_sum", 32'(out_sum), 32'(held_sum));
                check("stable_max", 32'(out_max), 32'(held_max));
                check("stable_zc",  32'(out_zero_cnt), 32'(held_zc));
            end
            held = 1'b0;
            if (!rst && out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_summary", 32'(out_sum), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_sum", 32'(out_sum), 32'(e.sum));
                        check("out_max", 32'(out_max), 32'(e.max));
                        check("out_zero_cnt", 32'(out_zero_cnt), 32'(e.zc));
                    end
                end else begin
                    held     = 1'b1;
                    held_sum = out_sum;
                    held_max = out_max;
                    held_zc  = out_zero_cnt;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_d      = 16'd77;
        out_ready = 1'b0;
        idle(2);
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_sum",     32'(out_sum), 32'd0);
        check("rst_max",     32'(out_max), 32'd0);
        check("rst_zc",      32'(out_zero_cnt), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Back-to-back window, one-cycle valid pulse.
        out_ready = 1'b1;
        push(18'd330, 16'd300, 3'd1);
        sample(16'd10);
        sample(16'd20);
        sample(16'd0);
        sample(16'd300);
        check("b2b_valid_rise", 32'(out_valid), 32'd1);
        tick();
        check("b2b_valid_fall", 32'(out_valid), 32'd0);

        // Full-scale samples with 0..3 bubble cycles between them.
        push(18'h3FFFC, 16'hFFFF, 3'd0);
        sample(16'hFFFF);
        sample(16'hFFFF);
        idle(1);
        sample(16'hFFFF);
        idle(2);
        check("bubble_no_early", 32'(out_valid), 32'd0);
        idle(1);
        sample(16'hFFFF);
        idle(1);

        // Backpressure: A held, B dropped.
        out_ready = 1'b0;
        push(18'd10, 16'd4, 3'd0);
        sample(16'd1);
        sample(16'd2);
        sample(16'd3);
        sample(16'd4);
        check("ovr_pre", 32'(overrun), 32'd0);
        for (int i = 0; i < WIN; i++) sample(16'd5);
        check("ovr_set",     32'(overrun), 32'd1);
        check("ovr_hold_sum", 32'(out_sum), 32'd10);
        check("ovr_hold_max", 32'(out_max), 32'd4);
        out_ready = 1'b1;
        tick();
        check("ovr_drained", 32'(out_valid), 32'd0);
        check("ovr_sticky",  32'(overrun), 32'd1);
        out_ready = 1'b0;

        // Accept and complete on the same edge.
        pulse_rst();
        check("rst_clears_ovr", 32'(overrun), 32'd0);
        push(18'd8, 16'd6, 3'd2);
        push(18'd36, 16'd9, 3'd0);
        sample(16'd2);
        sample(16'd0);
        sample(16'd0);
        sample(16'd6);
        idle(2);
        sample(16'd9);
        sample(16'd9);
        sample(16'd9);
        out_ready = 1'b1;
        sample(16'd9);
        check("sim_valid",   32'(out_valid), 32'd1);
        check("sim_sum",     32'(out_sum), 32'd36);
        check("sim_overrun", 32'(overrun), 32'd0);
        idle(1);

        // Mid-window reset discards the partial window.
        push(18'd4, 16'd1, 3'd0);
        sample(16'd7);
        sample(16'd7);
        pulse_rst();
        for (int i = 0; i < WIN; i++) sample(16'd1);
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_overrun",    32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hw2_result_accum

// File: doc/hw2_result_accum.md
# hw2_result_accum

Windowed result accumulator that sits directly downstream of the hw2 clock-gated multiply stage and consumes its 16-bit `d` result stream. Every `WIN` valid results it emits a summary: the wide sum, the maximum, and the count of zero results, which is the number of gated `c == 0` operations in the window. Output uses a valid/ready handshake toward the reporting logic. The input side never back-pressures, because the multiply stage cannot stall.

## Interface
- `WIN`, 8: samples per window, ≥2.
- `DW`, 16: input result width, matching the multiply stage's `d`.
- `ACC_W`, 19: sum width, `DW + clog2(WIN)`; must be large enough that the sum cannot overflow.
- `ZC_W`, 4: zero-count width, `clog2(WIN+1)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_d` holds a result this cycle; aligned with the multiply stage's 2-cycle output latency.
- `in_d` in DW: multiply result.
- `out_ready` in 1: consumer accepts the summary.
- `out_valid` out 1: summary held and valid.
- `out_sum` out ACC_W: sum of the window's samples.
- `out_max` out DW: unsigned maximum sample in the window.
- `out_zero_cnt` out ZC_W: number of samples equal to 0.
- `overrun` out 1: sticky flag; a completed window was dropped.

## Operation
- Working registers: `acc`, `cur_max`, `zc`, and sample counter `cnt` (0..WIN-1). A separate output holding register drives the `out_*` summary ports.
- Accepted sample (`in_valid` = 1):
  - `acc += zero-extended in_d`.
  - `cur_max = max(cur_max, in_d)`, unsigned.
  - `zc += (in_d == 0)`.
  - `cnt += 1`.
- When `in_valid` = 0, all working registers hold.
- Window completion occurs when a sample is accepted while `cnt == WIN-1`:
  - The final values, including that sample, go to the holding register if it is free (or being freed this cycle); `out_valid` is then set.
  - Otherwise the window is dropped and `overrun` is set.
  - In both cases the working registers clear to 0 on that same edge. The next cycle's sample starts a fresh window with no lost samples.
- Holding register FSM:
  - States: `EMPTY` (`out_valid` = 0) and `FULL` (`out_valid` = 1).
  - `EMPTY` → `FULL` on completion.
  - `FULL` → `EMPTY` on `out_ready` with no completion.
  - `FULL` → `FULL`, with new data loaded, on `out_ready` and completion in the same cycle. This is not an overrun.
  - `FULL` with completion and no `out_ready`: data held unchanged, `overrun` set to 1.
- While `out_valid` = 1 and no transfer occurs, all `out_*` values are stable.
- `overrun` clears only on `rst`.
- Arithmetic: all unsigned; no wrap, given the `ACC_W` rule above.

## Timing
- Reset, synchronous: on a `rst`-high edge, all working registers, the holding register, `out_valid`, `out_sum`, `out_max`, `out_zero_cnt`, and `overrun` become 0, and the FSM goes to `EMPTY`. `rst` has priority over `in_valid` and `out_ready`.
- Reset in the middle of a window discards the partial window.
- Latency: `out_valid` rises on the edge that accepts the WIN-th sample, so it is visible in the following cycle.
- Handshake:
  - A transfer occurs on an edge where `out_valid` && `out_ready` are both 1.
  - `out_valid` is independent of `out_ready`; there is no combinational path from `out_ready` to any output.
- Throughput: one sample per cycle sustained. At most one summary per WIN cycles.

## Structure
- Shared package `hw2_pkg`:
  - `DW` = 16.
  - Default `WIN` constant.
  - `clog2` function, used to derive `ACC_W` and `ZC_W`.
  - FSM state encoding: `ST_EMPTY` = 0, `ST_FULL` = 1.
- Single module with no sub-module. The window counter and the max compare are too small to split out.

## Test plan
All scenarios use `WIN` = 4, `ACC_W` = 18, `ZC_W` = 3.
- Reset: `rst` = 1 for 2 cycles with `in_valid` = 1 → all outputs 0. The first window starts at the first post-reset sample.
- Back-to-back window: `in_d` = 10, 20, 0, 300 in consecutive cycles, `out_ready` = 1 → one cycle after the 4th sample, `out_valid` = 1 with `out_sum` = 330, `out_max` = 300, `out_zero_cnt` = 1. `out_valid` pulses for 1 cycle.
- Bubbles and saturation: samples 0xFFFF ×4 with `in_valid` gaps of 0–3 cycles → `out_sum` = 0x3FFFC, `out_max` = 0xFFFF, `out_zero_cnt` = 0. Gap cycles are not counted.
- Backpressure and overrun: `out_ready` = 0; window A = {1,2,3,4}, then window B = {5,5,5,5} → outputs hold A (`out_sum` = 10, `out_max` = 4) and `overrun` = 1 after B. Raising `out_ready` transfers A, then `out_valid` = 0.
- Simultaneous accept and complete: window A held; `out_ready` = 1 on the same cycle window B's 4th sample arrives → `out_valid` stays 1 showing B's values, and `overrun` stays 0.
- Mid-window reset: samples 7, 7, then `rst` pulse, then 1, 1, 1, 1 → single summary with `out_sum` = 4, `out_max` = 1, `out_zero_cnt` = 0.
